// File: rtl/mac_seq_if.sv
// Operand/result handshake bundle for the mac_seq multiply-accumulate unit.
// master = operand source / result consumer, slave = the unit itself.
interface mac_seq_if #(
    parameter int bw = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [bw-1:0]   a;
    logic [bw-1:0]   b;
    logic [bw-1:0]   c;
    logic            out_valid;
    logic            out_ready;
    logic [2*bw-1:0] p;
    logic            ovf;

    modport master (
        output in_valid, a, b, c, out_ready,
        input  in_ready, out_valid, p, ovf
    );

    modport slave (
        input  in_valid, a, b, c, out_ready,
        output in_ready, out_valid, p, ovf
    );
endinterface

// File: rtl/mac_seq.sv
// Sequential shift-and-add multiply-accumulate: p = a*b + c, fixed latency of
// bw cycles, valid/ready handshake on operand and result sides.
module mac_seq #(
    parameter int bw = 8
) (
    input  logic      clk,
    input  logic      rst,
    mac_seq_if.slave  bus
);
    localparam int cw = $clog2(bw + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [2*bw-1:0] acc;
    logic [2*bw-1:0] mcand;
    logic [2*bw-1:0] acc_step;
    logic [bw-1:0]   mplier;
    logic [cw-1:0]   cnt;

    logic            accept;
    logic            last_step;
    logic            in_ready_d;
    logic            out_valid_d;
    logic [2*bw-1:0] p_q;
    logic            ovf_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        accept      = 1'b0;
        last_step   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == cw'(bw - 1)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One partial product per step; the sum never exceeds 2*bw bits.
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    // NOTE: the working registers are not reset; they are always reloaded on
    // acceptance before being read, and only p/ovf are architecturally visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc    <= {{bw{1'b0}}, bus.c};
            mcand  <= {{bw{1'b0}}, bus.a};
            mplier <= bus.b;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + cw'(1);
        end
    end

    // Result is published only on completion and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            ovf_q <= 1'b0;
        end else if (last_step) begin
            p_q   <= acc_step;
            ovf_q <= |acc_step[2*bw-1:bw];
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_d;
    assign bus.p         = p_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: a cycle-timed arithmetic model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_mac_seq;
    localparam int bw = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_seq_if #(.bw(bw)) bus ();

    mac_seq #(.bw(bw)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: result = a*b + c, available bw edges after acceptance, held until taken.
    int              cyc = 0;
    bit              m_init = 0;
    bit              m_active = 0;
    int              m_ready_at = 0;
    int              m_res = 0;
    logic [2*bw-1:0] m_p = '0;
    logic            m_ovf = 1'b0;
    logic [2*bw-1:0] res_q[$];
    logic [2*bw-1:0] dut_q[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_init   = 1;
            m_active = 0;
            m_p      = '0;
            m_ovf    = 1'b0;
        end else if (m_init) begin
            if (m_active) begin
                if (cyc == m_ready_at) begin
                    m_p   = m_res[2*bw-1:0];
                    m_ovf = (m_res >> bw) != 0;
                end else if (cyc > m_ready_at && bus.out_ready) begin
                    m_active = 0;
                    res_q.push_back(m_p);
                end
            end else if (bus.in_valid) begin
                m_active   = 1;
                m_res      = int'(bus.a) * int'(bus.b) + int'(bus.c);
                m_ready_at = cyc + bw;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("in_ready", 32'(bus.in_ready), 32'(!m_active));
            check("out_valid", 32'(bus.out_valid), 32'(m_active && cyc >= m_ready_at));
            check("p", 32'(bus.p), 32'(m_p));
            check("ovf", 32'(bus.ovf), 32'(m_ovf));
        end
        if (bus.out_valid && bus.out_ready) dut_q.push_back(bus.p);
    end

    function automatic logic [31:0] last_model_res();
        return (res_q.size() == 0) ? 32'hFFFF_FFFF : 32'(res_q[res_q.size()-1]);
    endfunction

    // Called at a negedge; returns at the negedge following the acceptance edge.
    task automatic send(input logic [bw-1:0] a, input logic [bw-1:0] b, input logic [bw-1:0] c,
                        input bit hold, output int t);
        bit ok = 0;
        t = -1;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.c = c;
        for (int k = 0; k < 8 * bw; k++) begin
            if (bus.in_ready) begin
                t  = cyc + 1;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic op(input logic [bw-1:0] a, input logic [bw-1:0] b, input logic [bw-1:0] c,
                      output logic [2*bw-1:0] pv, output logic ov);
        int t;
        bit seen = 0;
        pv = '0;
        ov = 1'b0;
        bus.out_ready = 1'b1;
        send(a, b, c, 1'b0, t);
        for (int k = 0; k < 4 * bw; k++) begin
            if (bus.out_valid) begin
                seen = 1;
                pv   = bus.p;
                ov   = bus.ovf;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("result_timeout", 32'd0, 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (bus.in_ready) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*bw-1:0] pv;
        logic            ov;
        int              t1, t2, first, low, base;
        logic [bw-1:0]   bvals[8];
        bvals = '{8'd1, 8'd2, 8'd3, 8'd7, 8'd16, 8'd100, 8'd254, 8'd255};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_p", 32'(bus.p), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 13*11+5: latency 8, in_ready low for 9 cycles
        bus.out_ready = 1'b1;
        send(8'd13, 8'd11, 8'd5, 1'b0, t1);
        first = -1;
        low   = 0;
        pv    = '0;
        ov    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (first < 0 && bus.out_valid) begin
                first = k;
                pv    = bus.p;
                ov    = bus.ovf;
            end
            if (bus.in_ready) break;
            low++;
            @(negedge clk);
        end
        check("t1_latency", 32'(first), 32'd8);
        check("t1_busy_cycles", 32'(low), 32'd9);
        check("t1_p", 32'(pv), 32'd148);
        check("t1_ovf", 32'(ov), 32'd0);
        check("model_148", last_model_res(), 32'd148);

        // Extremes
        op(8'd255, 8'd255, 8'd255, pv, ov);
        check("max_p", 32'(pv), 32'd65280);
        check("max_ovf", 32'(ov), 32'd1);
        check("model_65280", last_model_res(), 32'd65280);
        op(8'd0, 8'd200, 8'd7, pv, ov);
        check("zero_p", 32'(pv), 32'd7);
        check("zero_ovf", 32'(ov), 32'd0);

        // Divider reconstruction: (a/b)*b + a%b == a
        for (int ai = 0; ai < 256; ai += 17) begin
            foreach (bvals[j]) begin
                op(8'(ai / int'(bvals[j])), bvals[j], 8'(ai % int'(bvals[j])), pv, ov);
                check("div_recon", 32'(pv), 32'(ai));
            end
        end

        // Backpressure: result held while out_ready low, new operands ignored
        bus.out_ready = 1'b0;
        send(8'd3, 8'd4, 8'd0, 1'b0, t1);
        for (int k = 0; k < 4 * bw; k++) begin
            if (bus.out_valid) break;
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.a = 8'(50 + i);
            bus.b = 8'd9;
            bus.c = 8'd1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_p", 32'(bus.p), 32'd12);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_p", 32'(bus.p), 32'd12);

        // Reset on the 4th RUN edge discards the operation
        send(8'd200, 8'd200, 8'd0, 1'b0, t1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_p", 32'(bus.p), 32'd0);
        check("midrst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        op(8'd2, 8'd3, 8'd1, pv, ov);
        check("post_rst_p", 32'(pv), 32'd7);

        // Back-to-back with in_valid held high
        bus.out_ready = 1'b1;
        base = dut_q.size();
        send(8'd17, 8'd19, 8'd3, 1'b1, t1);
        send(8'd250, 8'd6, 8'd100, 1'b0, t2);
        check("b2b_spacing", 32'(t2 - t1), 32'(bw + 2));
        for (int k = 0; k < 6 * bw; k++) begin
            if (dut_q.size() >= base + 2) break;
            @(negedge clk);
        end
        if (dut_q.size() >= base + 2) begin
            check("b2b_first", 32'(dut_q[base]), 32'd326);
            check("b2b_second", 32'(dut_q[base+1]), 32'd1600);
        end else begin
            check("b2b_results_count", 32'(dut_q.size() - base), 32'd2);
        end
        check("model_1600", last_model_res(), 32'd1600);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_seq.md
# mac_seq

Sequential shift-and-add multiply-accumulate unit computing p = a*b + c. It is the reconstruction direction of the team's combinational divider `div`: given quotient, divisor and remainder it rebuilds the dividend. It is used in the `fib` arithmetic path to check divider results (q*b + r == a) and as the general-purpose multiplier for the sequence generator. Fixed latency and a valid/ready handshake on both sides let it sit directly between pipeline stages.

## Interface
- bw, 8: operand width in bits; bw >= 2.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b, c valid.
- in_ready  out  1  unit idle and able to accept operands.
- a  in  bw  multiplicand, unsigned.
- b  in  bw  multiplier, unsigned.
- c  in  bw  addend, unsigned; the remainder in divider checks.
- out_valid  out  1  result on p/ovf valid.
- out_ready  in  1  consumer accepts result.
- p  out  2*bw  result a*b + c, unsigned.
- ovf  out  1  p[2*bw-1:bw] != 0; the result does not fit in bw bits.

## Operation
- FSM states: IDLE, RUN, DONE; reset state is IDLE.
- in_ready = (state == IDLE); out_valid = (state == DONE); both are decoded from registered state only.
- IDLE: on an edge with in_valid && in_ready:
  - latch acc = {bw'b0, c}, mcand = {bw'b0, a} (2*bw wide), mplier = b, cnt = 0
  - go to RUN
- RUN, one step per edge:
  - if mplier[0] == 1, acc = acc + mcand (2*bw-bit add, no carry out)
  - mcand <<= 1; mplier >>= 1; cnt = cnt + 1
  - on the step where cnt reaches bw: copy acc to p, set ovf = |acc[2*bw-1:bw], go to DONE
- DONE: p and ovf are held stable. On an edge with out_ready = 1, go to IDLE.
- Range: the maximum result is (2^bw-1)^2 + (2^bw-1) = 2^(2bw) - 2^bw, so it always fits in 2*bw bits. No truncation, no wrap.
- Iteration count is always bw. There is no early exit on a zero multiplier.
- in_valid outside IDLE is ignored. No operand is queued or lost silently: the source must hold operands until in_ready.
- After the handshake, p and ovf keep their value until the next completion.
- Inputs a, b, c are sampled only on the acceptance edge. Later changes have no effect on the running operation.
- Reset at any cycle, including mid-RUN or DONE:
  - next state IDLE, p = 0, ovf = 0
  - the in-flight result is discarded and no out_valid is produced for it
  - rst has priority over every handshake in the same cycle.

## Timing
- Reset values: in_ready = 1, out_valid = 0, p = 0, ovf = 0 in the first cycle after the reset edge.
- Acceptance on edge T. in_ready is low from T+1.
- RUN steps occur on edges T+1 .. T+bw.
- out_valid and the new p/ovf are visible from edge T+bw onward, so latency is bw cycles from acceptance to result.
- If out_ready is already high when out_valid rises, the handshake completes on edge T+bw+1 and in_ready is high after it.
- Maximum throughput is one operation per bw+2 cycles.
- In DONE, in_valid = 1 and out_ready = 1 together: only the output handshake occurs. The input is accepted no earlier than the next edge.
- No combinational path from any input to any output.

## Test plan
- bw=8, a=13, b=11, c=5, out_ready=1 -> out_valid rises 8 cycles after acceptance, p=148, ovf=0. in_ready is low for exactly 9 cycles.
- bw=8, a=255, b=255, c=255 -> p=0xFF00 (65280), ovf=1. Also a=0, b=200, c=7 -> p=7, ovf=0.
- Divider reconstruction: sweep a in 0..255, b in 1..255 through `div`, with c = a mod b and mac_seq(a/b, b, c) -> p == a for every pair.
- Backpressure: a=3, b=4, c=0 with out_ready held low for 6 cycles after out_valid -> p=12 stable and out_valid high throughout. New in_valid pulses during this window are not accepted.
- Reset at the 4th RUN cycle of a=200, b=200 -> next cycle in_ready=1, out_valid=0, p=0, ovf=0. A following a=2, b=3, c=1 yields p=7.
- Back-to-back: in_valid held high with two operand sets and out_ready=1 -> the second set is accepted exactly bw+2 cycles after the first, and both results are correct.
